// File: rtl/uart_pkg.sv
// UART shared types: FSM state encoding used by
// both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous
// single-bit input; resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/transmitter.sv
// 8N1 UART transmitter; accepts a byte when
// send is high and the line is idle.
module transmitter
  import uart_pkg::*;
#(
  parameter int BAUD       = 115200,
  parameter int CLOCK_FREQ = 25_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       send,
  output logic       txd,
  output logic       busy
);

  localparam int BIT_PERIOD = CLOCK_FREQ / BAUD;
  localparam int CW = $clog2(BIT_PERIOD);
  localparam logic [CW-1:0] BIT_LAST =
    CW'(BIT_PERIOD - 1);

  state_t         state;
  logic [CW-1:0]  baud_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shift;

  assign busy = (state != IDLE);

  always_comb begin
    txd = 1'b1;
    unique case (state)
      START_BIT: txd = 1'b0;
      DATA_BITS: txd = shift[bit_idx];
      default:   txd = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (send) begin
            shift <= data;
            state <= START_BIT;
          end
        end
        START_BIT: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            state    <= DATA_BITS;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA_BITS: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP_BIT;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP_BIT: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/receiver.sv
// 8N1 UART receiver with mid-bit sampling, a one-byte
// holding register, framing-error and overrun pulses.
module receiver
  import uart_pkg::*;
#(
  parameter int BAUD       = 115200,
  parameter int CLOCK_FREQ = 25_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] data_out,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       framing_err,
  output logic       overrun
);

  localparam int BIT_PERIOD = CLOCK_FREQ / BAUD;
  localparam int HALF = BIT_PERIOD / 2;
  localparam int CW = $clog2(BIT_PERIOD);
  localparam logic [CW-1:0] BIT_LAST =
    CW'(BIT_PERIOD - 1);
  localparam logic [CW-1:0] HALF_LAST =
    CW'(HALF - 1);

  state_t         state;
  logic [CW-1:0]  baud_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shift;
  logic           rxd_s;
  logic           rxd_prev;
  logic           deliver;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxd_s)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rxd_prev <= 1'b0;
    else        rxd_prev <= rxd_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      deliver     <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      deliver     <= 1'b0;
      framing_err <= 1'b0;
      unique case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (rxd_prev && !rxd_s) state <= START_BIT;
        end
        // re-check the start bit mid-way to reject glitches
        START_BIT: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            state    <= rxd_s ? IDLE : DATA_BITS;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA_BITS: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt       <= '0;
            shift[bit_idx] <= rxd_s;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP_BIT;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP_BIT: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            state    <= IDLE;
            if (rxd_s) deliver     <= 1'b1;
            else       framing_err <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // holding register: a byte landing on a full,
  // unconsumed register is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= 8'h00;
      valid    <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (deliver) begin
        if (!valid || ready) begin
          data_out <= shift;
          valid    <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_receiver.sv
// Bench for receiver: transmitter-driven frames plus
// hand-driven line patterns, scoreboard of bytes.
module tb_receiver;

  localparam int BAUD = 115200;
  localparam int CLOCK_FREQ = 25_500_000;
  localparam int BP = CLOCK_FREQ / BAUD;
  localparam int LAT_NOM = (19 * BP) / 2 + 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd;
  logic [7:0] data_out;
  logic       valid;
  logic       ready = 1'b1;
  logic       busy;
  logic       framing_err;
  logic       overrun;

  logic [7:0] tx_data = 8'h00;
  logic       tx_send = 1'b0;
  logic       txd;
  logic       tx_busy;
  logic       use_man = 1'b0;
  logic       man_rxd = 1'b1;

  int compared = 0;
  int mismatched = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  int n_taken = 0;
  int n_brise = 0;
  logic busy_q = 1'b0;
  logic [7:0] sb[$];

  assign rxd = use_man ? man_rxd : txd;

  always #5 clk = ~clk;

  receiver #(.BAUD(BAUD), .CLOCK_FREQ(CLOCK_FREQ)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rxd         (rxd),
    .data_out    (data_out),
    .valid       (valid),
    .ready       (ready),
    .busy        (busy),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  transmitter #(.BAUD(BAUD), .CLOCK_FREQ(CLOCK_FREQ)) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (tx_data),
    .send  (tx_send),
    .txd   (txd),
    .busy  (tx_busy)
  );

  always @(negedge clk) begin
    logic [7:0] exp;
    if (valid === 1'b1) n_valid++;
    if (framing_err === 1'b1) n_ferr++;
    if (overrun === 1'b1) n_ovr++;
    if (busy === 1'b1 && busy_q !== 1'b1) n_brise++;
    busy_q = busy;
    if (valid === 1'b1 && ready === 1'b1) begin
      n_taken++;
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL sb_unexpected got=%h want=none",
                 data_out);
      end else begin
        exp = sb.pop_front();
        if (data_out !== exp) begin
          mismatched++;
          $display("FAIL sb_byte got=%h want=%h",
                   data_out, exp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    while (tx_busy && n < 5000) begin
      tick(1);
      n++;
    end
    tx_data = b;
    tx_send = 1'b1;
    tick(1);
    tx_send = 1'b0;
  endtask

  task automatic wait_idle(input int extra);
    int n = 0;
    while (tx_busy && n < 5000) begin
      tick(1);
      n++;
    end
    if (tx_busy) begin
      compared++;
      mismatched++;
      $display("FAIL tx_timeout got=busy want=idle");
    end
    tick(extra);
  endtask

  task automatic man_bit(input logic v);
    man_rxd = v;
    tick(BP);
  endtask

  task automatic test_reset;
    use_man = 1'b1;
    man_rxd = 1'b0;
    rst_n = 1'b0;
    tick(5);
    compared++;
    if ({data_out, valid, busy, framing_err, overrun}
        !== 12'h000) begin
      mismatched++;
      $display("FAIL reset_outs got=%h/%b%b%b%b want=00/0000",
               data_out, valid, busy, framing_err, overrun);
    end
    rst_n = 1'b1;
    tick(20);
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL low_at_release got=%b want=0", busy);
    end
    man_rxd = 1'b1;
    tick(20);
    compared++;
    if (busy !== 1'b0 || n_valid != 0) begin
      mismatched++;
      $display("FAIL rise_not_start got=%b/%0d want=0/0",
               busy, n_valid);
    end
    use_man = 1'b0;
    tick(5);
  endtask

  task automatic test_single;
    int n, v0, f0;
    ready = 1'b1;
    v0 = n_valid;
    f0 = n_ferr;
    sb.push_back(8'hA5);
    send(8'hA5);
    n = 0;
    while (txd !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (valid !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (n < LAT_NOM - 2 || n > LAT_NOM + 2) begin
      mismatched++;
      $display("FAIL a5_latency got=%0d want=%0d+-2",
               n, LAT_NOM);
    end
    wait_idle(20);
    compared++;
    if (n_valid - v0 != 1) begin
      mismatched++;
      $display("FAIL a5_valid_width got=%0d want=1",
               n_valid - v0);
    end
    compared++;
    if (n_ferr != f0 || sb.size() != 0) begin
      mismatched++;
      $display("FAIL a5_clean got=%0d/%0d want=0/0",
               n_ferr - f0, sb.size());
    end
  endtask

  task automatic test_back_to_back;
    int t0, f0, o0;
    t0 = n_taken;
    f0 = n_ferr;
    o0 = n_ovr;
    sb.push_back(8'h00);
    sb.push_back(8'hFF);
    send(8'h00);
    send(8'hFF);
    wait_idle(20);
    compared++;
    if (n_taken - t0 != 2 || sb.size() != 0) begin
      mismatched++;
      $display("FAIL b2b_count got=%0d want=2",
               n_taken - t0);
    end
    compared++;
    if (n_ferr != f0 || n_ovr != o0) begin
      mismatched++;
      $display("FAIL b2b_errs got=%0d/%0d want=0/0",
               n_ferr - f0, n_ovr - o0);
    end
  endtask

  task automatic test_glitch;
    int v0, f0, b0;
    logic seen;
    v0 = n_valid;
    f0 = n_ferr;
    b0 = n_brise;
    use_man = 1'b1;
    man_rxd = 1'b0;
    tick(10);
    seen = busy;
    tick(40);
    man_rxd = 1'b1;
    tick(200);
    compared++;
    if (seen !== 1'b1 || n_brise - b0 != 1) begin
      mismatched++;
      $display("FAIL glitch_busy_rise got=%b/%0d want=1/1",
               seen, n_brise - b0);
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL glitch_busy_fall got=%b want=0", busy);
    end
    compared++;
    if (n_valid != v0 || n_ferr != f0) begin
      mismatched++;
      $display("FAIL glitch_quiet got=%0d/%0d want=0/0",
               n_valid - v0, n_ferr - f0);
    end
    use_man = 1'b0;
  endtask

  task automatic test_framing;
    int v0, f0, o0, t0;
    logic [7:0] b;
    b = 8'h3C;
    v0 = n_valid;
    f0 = n_ferr;
    o0 = n_ovr;
    use_man = 1'b1;
    man_rxd = 1'b1;
    tick(10);
    man_bit(1'b0);
    for (int i = 0; i < 8; i++) man_bit(b[i]);
    man_bit(1'b0);
    man_bit(1'b1);
    man_bit(1'b1);
    compared++;
    if (n_ferr - f0 != 1) begin
      mismatched++;
      $display("FAIL ferr_pulse got=%0d want=1",
               n_ferr - f0);
    end
    compared++;
    if (n_valid != v0 || n_ovr != o0) begin
      mismatched++;
      $display("FAIL ferr_no_valid got=%0d/%0d want=0/0",
               n_valid - v0, n_ovr - o0);
    end
    use_man = 1'b0;
    tick(5);
    t0 = n_taken;
    sb.push_back(8'h5A);
    send(8'h5A);
    wait_idle(20);
    compared++;
    if (n_taken - t0 != 1 || sb.size() != 0) begin
      mismatched++;
      $display("FAIL ferr_recover got=%0d want=1",
               n_taken - t0);
    end
  endtask

  task automatic test_overrun;
    int o0;
    o0 = n_ovr;
    ready = 1'b0;
    sb.push_back(8'h11);
    send(8'h11);
    send(8'h22);
    wait_idle(20);
    compared++;
    if (data_out !== 8'h11 || valid !== 1'b1) begin
      mismatched++;
      $display("FAIL ovr_hold got=%h/%b want=11/1",
               data_out, valid);
    end
    compared++;
    if (n_ovr - o0 != 1) begin
      mismatched++;
      $display("FAIL ovr_pulse got=%0d want=1",
               n_ovr - o0);
    end
    ready = 1'b1;
    tick(2);
    compared++;
    if (valid !== 1'b0 || data_out !== 8'h11) begin
      mismatched++;
      $display("FAIL ovr_drain got=%b/%h want=0/11",
               valid, data_out);
    end
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL ovr_sb got=%0d want=0", sb.size());
    end
  endtask

  task automatic test_reset_mid;
    int t0, f0, o0, v0;
    ready = 1'b1;
    send(8'h77);
    tick(4 * BP);
    v0 = n_valid;
    rst_n = 1'b0;
    tick(5);
    compared++;
    if ({data_out, valid, busy, framing_err, overrun}
        !== 12'h000) begin
      mismatched++;
      $display("FAIL midrst_outs got=%h/%b%b%b%b want=00/0000",
               data_out, valid, busy, framing_err, overrun);
    end
    rst_n = 1'b1;
    tick(50);
    t0 = n_taken;
    f0 = n_ferr;
    o0 = n_ovr;
    sb.push_back(8'h88);
    send(8'h88);
    wait_idle(20);
    compared++;
    if (n_taken - t0 != 1 || n_valid - v0 != 1) begin
      mismatched++;
      $display("FAIL midrst_only88 got=%0d/%0d want=1/1",
               n_taken - t0, n_valid - v0);
    end
    compared++;
    if (n_ferr != f0 || n_ovr != o0 || sb.size() != 0) begin
      mismatched++;
      $display("FAIL midrst_clean got=%0d/%0d/%0d want=0/0/0",
               n_ferr - f0, n_ovr - o0, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_overrun();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
